// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - alu_op_e   : 4-bit ALU operation codes consumed by the ALU
//   - OPC_*      : RV32I major opcode constants
//   - imm_fmt_e  : which immediate format an instruction carries
//   - arith_op() : funct3 (+ alternate bit) to ALU op for OP / OP-IMM
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLA  = 4'd10,
    ALU_GEU  = 4'd11,
    ALU_GE   = 4'd12,
    ALU_EQ   = 4'd13,
    ALU_NE   = 4'd14
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U,
    IMM_SHAMT
  } imm_fmt_e;

  // alt selects SUB over ADD and SRA over SRL; ignored for the other funct3s.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode into ALU op and operands.
// Ports:
//   instr     in  : raw 32-bit instruction
//   pc        in  : instruction address (operand A for AUIPC)
//   rs1_data  in  : rs1 value (already forwarded by the caller if enabled)
//   rs2_data  in  : rs2 value
//   alu_op    out : ALU operation code (alu_pkg::alu_op_e)
//   alu_a     out : operand A
//   alu_b     out : operand B
//   is_branch out : op is a branch compare
//   illegal   out : instruction not decodable (forces ADD, A=B=0)
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            is_branch,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm;
  alu_op_e         op;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Format selection kept apart from the main decode so imm never feeds back
  // into the block that chooses it.
  always_comb begin
    fmt = IMM_NONE;
    case (opcode)
      OPC_OP_IMM:         fmt = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
      OPC_LOAD:           fmt = IMM_I;
      OPC_STORE:          fmt = IMM_S;
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      default:            fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'h000}));
      IMM_SHAMT: imm = XLEN'(instr[24:20]);
      default:   imm = '0;
    endcase
  end

  always_comb begin
    op        = ALU_ADD;
    alu_a     = '0;
    alu_b     = '0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_a = rs1_data;
        alu_b = rs2_data;
        if (f7 == F7_BASE) begin
          op = arith_op(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          op = arith_op(f3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        alu_a = rs1_data;
        alu_b = imm;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b001: begin
            op = ALU_SLL;
            if (f7 != F7_BASE) illegal = 1'b1;
          end
          3'b101: begin
            if (f7 == F7_BASE)     op = ALU_SRL;
            else if (f7 == F7_ALT) op = ALU_SRA;
            else                   illegal = 1'b1;
          end
          default: op = arith_op(f3, 1'b0);
        endcase
      end
      OPC_LUI: begin
        alu_b = imm;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm;
      end
      OPC_BRANCH: begin
        alu_a     = rs1_data;
        alu_b     = rs2_data;
        is_branch = 1'b1;
        case (f3)
          3'b000:  op = ALU_EQ;
          3'b001:  op = ALU_NE;
          3'b100:  op = ALU_SLT;
          3'b101:  op = ALU_GE;
          3'b110:  op = ALU_SLTU;
          3'b111:  op = ALU_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        alu_a = rs1_data;
        alu_b = imm;
      end
      default: illegal = 1'b1;
    endcase

    // Illegal entries still flow downstream, but with a harmless payload.
    if (illegal) begin
      op        = ALU_ADD;
      alu_a     = '0;
      alu_b     = '0;
      is_branch = 1'b0;
    end
  end

  assign alu_op = op;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: execute-entry stage in front of the ALU. Decodes the incoming
// instruction and holds the result in a registered valid/ready output with a
// 2-entry skid buffer (main drives the outputs, skid absorbs one stall).
// Optional feature macro: ALU_ISSUE_FWD_EN adds wb_valid/wb_rd/wb_data and
// forwards the write-back value into rs1/rs2 at capture time.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   flush                : drop main and skid entries and any same-edge input
//   in_valid / in_ready  : upstream handshake (in_ready = !skid valid)
//   instr, pc            : instruction and its address
//   rs1_data, rs2_data   : register operands
//   out_valid/out_ready  : downstream handshake
//   alu_op, alu_a, alu_b : ALU op and operands of the held entry
//   out_pc               : pc of the held entry
//   is_branch, illegal   : decode flags of the held entry
module alu_issue
  import alu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_OPS = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] out_pc,
  output logic            is_branch,
  output logic            illegal
);

  // Entry layout: {op, a, b, pc, is_branch, illegal}
  localparam int EW     = 4 + 3 * XLEN + 2;
  localparam int OP_LSB = 3 * XLEN + 2;
  localparam int A_LSB  = 2 * XLEN + 2;
  localparam int B_LSB  = XLEN + 2;
  localparam int PC_LSB = 2;
  localparam logic [EW-1:0] ENTRY_RST = {ALU_ADD, RESET_PC_OPS, RESET_PC_OPS, RESET_PC_OPS, 2'b00};

  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_branch;
  logic            dec_illegal;
  logic [EW-1:0]   in_entry;
  logic            accept;

  logic [EW-1:0]   main_q, main_d;
  logic [EW-1:0]   skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;

`ifdef ALU_ISSUE_FWD_EN
  // x0 is never forwarded; decode only routes these into A/B for
  // register-sourced formats, so immediates/pc are unaffected.
  assign rs1_op = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[19:15]) ? wb_data : rs1_data;
  assign rs2_op = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[24:20]) ? wb_data : rs2_data;
`else
  assign rs1_op = rs1_data;
  assign rs2_op = rs2_data;
`endif

  alu_issue_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_op),
    .rs2_data  (rs2_op),
    .alu_op    (dec_op),
    .alu_a     (dec_a),
    .alu_b     (dec_b),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  assign in_entry = {dec_op, dec_a, dec_b, pc, dec_branch, dec_illegal};
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Main is free this edge. Skid holds the older entry, and in_ready is
      // low whenever it is occupied, so the two loads never collide.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= ENTRY_RST;
      skid_q       <= ENTRY_RST;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign alu_op    = main_q[OP_LSB +: 4];
  assign alu_a     = main_q[A_LSB +: XLEN];
  assign alu_b     = main_q[B_LSB +: XLEN];
  assign out_pc    = main_q[PC_LSB +: XLEN];
  assign is_branch = main_q[1];
  assign illegal   = main_q[0];

endmodule
